// File: rtl/adder_stim_gen.sv
// adder_stim_gen: packetised operand stimulus for adder energy characterisation.
// Each payload flit flips a TOGGLE_W-bit window of the 2N-bit word. The window
// rotates through the word, wrapping from the top bit back to bit 0.
// Optional build macro ADDER_STIM_TOGGLE_CNT_EN enables the saturating toggle
// counter. Without the macro, toggle_cnt reads as zero.
module adder_stim_gen #(
    parameter int N        = 21,
    parameter int PAYLOAD  = 20,
    parameter int GAP      = 7,
    parameter int NUM_PKT  = 10,
    parameter int TOGGLE_W = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic [N-1:0]  input1,
    output logic [N-1:0]  input2,
    output logic          valid,
    output logic          busy,
    output logic          done,
    output logic [15:0]   pkt_cnt,
    output logic [31:0]   toggle_cnt
);

    // state | meaning
    // IDLE  | after reset, waiting for start
    // SEND  | emitting one payload flit per cycle
    // GAP   | idle cycles between packets, word held
    // DONE  | run complete, word held, start restarts
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

    localparam int W2 = 2 * N;
    localparam int OW = (W2 > 1) ? $clog2(W2) : 1;
    localparam int FW = (PAYLOAD > 1) ? $clog2(PAYLOAD) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [W2-1:0] BASE = {W2{1'b1}} >> (W2 - TOGGLE_W);
    localparam logic [OW:0]   W2_V = (OW + 1)'(W2);
    localparam logic [OW:0]   TW_V = (OW + 1)'(TOGGLE_W % W2);

    state_t          state_q;
    logic [W2-1:0]   word_q, word_d, mask_d;
    logic [OW-1:0]   offset_q, offset_d;
    logic [OW:0]     off_sum;
    logic [FW-1:0]   flit_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic            valid_q, busy_q, done_q;
    logic [15:0]     pkt_cnt_q;
    logic [31:0]     toggle_cnt_q, toggle_cnt_d;
    logic            restart;

    // Next word: XOR in the rotated window and advance the offset modulo 2N.
    always_comb begin
        mask_d   = (BASE << offset_q) | (BASE >> (W2 - int'(offset_q)));
        word_d   = word_q ^ mask_d;
        off_sum  = {1'b0, offset_q} + TW_V;
        offset_d = (off_sum >= W2_V) ? OW'(off_sum - W2_V) : OW'(off_sum);
    end

`ifdef ADDER_STIM_TOGGLE_CNT_EN
    logic [31:0] pop;
    logic [32:0] tsum;
    // Saturating accumulation of bits flipped by the current flit.
    always_comb begin
        pop          = 32'($countones(word_d ^ word_q));
        tsum         = {1'b0, toggle_cnt_q} + {1'b0, pop};
        toggle_cnt_d = tsum[32] ? 32'hFFFF_FFFF : tsum[31:0];
    end
`else
    // Feature absent: counter held at zero.
    always_comb toggle_cnt_d = '0;
`endif

    // A start is taken in IDLE, or in DONE once done is showing (busy low).
    always_comb restart = start && ((state_q == S_IDLE) || (state_q == S_DONE && done_q));

    // Sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_q       <= '0;
            offset_q     <= '0;
            flit_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pkt_cnt_q    <= '0;
            toggle_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    valid_q <= 1'b0;
                    if (restart) begin
                        word_q       <= '0;
                        offset_q     <= '0;
                        flit_cnt_q   <= FW'(PAYLOAD - 1);
                        pkt_cnt_q    <= '0;
                        toggle_cnt_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        state_q      <= S_SEND;
                    end else if (state_q == S_DONE) begin
                        // First DONE cycle follows the last flit, so done rises here.
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                S_SEND: begin
                    word_q       <= word_d;
                    offset_q     <= offset_d;
                    valid_q      <= 1'b1;
                    toggle_cnt_q <= toggle_cnt_d;
                    if (flit_cnt_q == '0) begin
                        flit_cnt_q <= FW'(PAYLOAD - 1);
                        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        if (pkt_cnt_q == 16'(NUM_PKT - 1)) begin
                            state_q <= S_DONE;
                        end else if (GAP > 0) begin
                            gap_cnt_q <= GW'(GAP - 1);
                            state_q   <= S_GAP;
                        end
                    end else begin
                        flit_cnt_q <= flit_cnt_q - FW'(1);
                    end
                end
                S_GAP: begin
                    valid_q <= 1'b0;
                    if (gap_cnt_q == '0) begin
                        state_q <= S_SEND;
                    end else begin
                        gap_cnt_q <= gap_cnt_q - GW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign input1     = word_q[N-1:0];
    assign input2     = word_q[W2-1:N];
    assign valid      = valid_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pkt_cnt    = pkt_cnt_q;
    assign toggle_cnt = toggle_cnt_q;

endmodule

// File: tb/tb_adder_stim_gen.sv
// Bench for adder_stim_gen: scoreboard of expected flits checked by a monitor,
// plus directed framing, reset and restart checks.
module tb_adder_stim_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        start_b = 1'b0;
    logic [20:0] input1, input2, input1_b, input2_b;
    logic        valid, busy, done, valid_b, busy_b, done_b;
    logic [15:0] pkt_cnt, pkt_cnt_b;
    logic [31:0] toggle_cnt, toggle_cnt_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [41:0] exp_q[$];

    // First five flits of a run, computed by hand as {input2, input1}.
    logic [41:0] hand [5] = '{
        {21'h000000, 21'h0003FF},
        {21'h000000, 21'h0FFFFF},
        {21'h0001FF, 21'h1FFFFF},
        {21'h07FFFF, 21'h1FFFFF},
        {21'h1FFFFF, 21'h1FFF00}
    };

`ifdef ADDER_STIM_TOGGLE_CNT_EN
    localparam logic [31:0] EXP_TOGGLES = 32'd2000;
`else
    localparam logic [31:0] EXP_TOGGLES = 32'd0;
`endif

    always #5 clk = ~clk;

    adder_stim_gen u_dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .input1(input1), .input2(input2), .valid(valid), .busy(busy), .done(done),
        .pkt_cnt(pkt_cnt), .toggle_cnt(toggle_cnt)
    );

    adder_stim_gen #(.GAP(0), .NUM_PKT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .input1(input1_b), .input2(input2_b), .valid(valid_b), .busy(busy_b), .done(done_b),
        .pkt_cnt(pkt_cnt_b), .toggle_cnt(toggle_cnt_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected flits of one full default run: hand table first, bit-loop model after.
    task automatic push_run();
        logic [41:0] w;
        int off;
        w = '0;
        off = 0;
        for (int f = 0; f < 200; f++) begin
            for (int k = 0; k < 10; k++) w[(off + k) % 42] = ~w[(off + k) % 42];
            off = (off + 10) % 42;
            if (f < 5) exp_q.push_back(hand[f]);
            else       exp_q.push_back(w);
        end
    endtask

    // Monitor: every valid flit must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [41:0] e;
        if (rst_n && valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL flit_unexpected: got %0h expected none", {input2, input1});
            end else begin
                e = exp_q.pop_front();
                chk("flit", {22'b0, input2, input1}, {22'b0, e});
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_outputs", {input1, input2, valid, busy, done}, '0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_toggle_cnt", toggle_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        chk("idle_no_valid", {valid, busy, done}, 0);

        // Full default run with a start pulse while busy
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {valid, busy}, 2'b01);
        for (int i = 0; i < 263; i++) begin
            start = (i == 100);
            tick();
            chk("frame_valid", valid, ((i % 27) < 20));
            chk("frame_done_low", done, 0);
        end
        start = 1'b0;
        tick();
        chk("done_rise", {done, busy, valid}, 3'b100);
        chk("done_pkt_cnt", pkt_cnt, 10);
        chk("done_toggle_cnt", toggle_cnt, EXP_TOGGLES);
        repeat (5) tick();
        chk("done_hold", {done, valid}, 2'b10);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Restart from DONE, then reset at flit 5 of packet 3
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i <= 58; i++) tick();
        chk("pre_abort_valid", valid, 1);
        chk("pre_abort_pkt_cnt", pkt_cnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", {input1, input2, valid, busy, done}, '0);
        chk("async_rst_counts", {pkt_cnt, toggle_cnt}, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("post_rst_idle", {valid, busy, done}, 0);
        end

        // GAP=0, NUM_PKT=2: 40 back-to-back flits then done
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("b2b_valid", valid_b, 1);
            if (i == 0) chk("b2b_first_flit", {input2_b, input1_b}, {21'h0, 21'h3FF});
        end
        tick();
        chk("b2b_done", {done_b, valid_b, busy_b}, 3'b100);
        chk("b2b_pkt_cnt", pkt_cnt_b, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
